// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports, one writeback port,
// write-through bypass and a hardwired-zero entry 0.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    input  logic [4:0]  WA,
    input  logic        WE,
    input  logic [1:0]  wb_sel,
    input  logic [31:0] alu_out,
    input  logic [31:0] mem_data,
    input  logic [31:0] pc_plus4,
    output logic [31:0] R1D1,
    output logic [31:0] R2D2,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC   = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    always_comb begin
        wb_data = '0;
        case (wb_sel_e'(wb_sel))
            WB_ALU:  wb_data = alu_out;
            WB_MEM:  wb_data = mem_data;
            WB_PC:   wb_data = pc_plus4;
            default: wb_data = '0;
        endcase
    end

    assign wr_en = WE && (WA != 5'd0) && (wb_sel_e'(wb_sel) != WB_NONE);

    // Entry 0 is forced to zero here so it can never capture a value.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WA] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reset and address 0 dominate the bypass so both ports always agree.
    always_comb begin
        R1D1 = regs_q[RA1];
        if (rst || (RA1 == 5'd0)) begin
            R1D1 = '0;
        end else if (wr_en && (WA == RA1)) begin
            R1D1 = wb_data;
        end
    end

    always_comb begin
        R2D2 = regs_q[RA2];
        if (rst || (RA2 == 5'd0)) begin
            R2D2 = '0;
        end else if (wr_en && (WA == RA2)) begin
            R2D2 = wb_data;
        end
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001: clk  input  1  single system clock; all register updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high; clears register array.
REQ-003: RA1  input  5  read address, port 1.
REQ-004: RA2  input  5  read address, port 2.
REQ-005: WA  input  5  write address.
REQ-006: WE  input  1  write enable, sampled on rising clk.
REQ-007: wb_sel  input  2  write-data source: 00 alu_out, 01 mem_data, 10 pc_plus4, 11 reserved.
REQ-008: alu_out  input  32  ALU result for writeback.
REQ-009: mem_data  input  32  load data for writeback.
REQ-010: pc_plus4  input  32  link value for JAL/JALR writeback.
REQ-011: R1D1  output  32  read data, port 1; feeds operand A.
REQ-012: R2D2  output  32  read data, port 2; feeds the operand-B select (R2D2 vs immediate).
REQ-013: wb_data  output  32  selected write data, combinational, for debug/forwarding.

Function
REQ-014: Storage SHALL be 32 entries x 32 bits; entry 0 SHALL read as 0 always and never hold a written value.
REQ-015: wb_data SHALL equal alu_out, mem_data, pc_plus4 for wb_sel 00, 01, 10; for 11 it SHALL be 0.
REQ-016: Effective write SHALL be WE=1 and WA!=0 and wb_sel!=11; on the rising clk edge with an effective write, entry WA SHALL take wb_data.
REQ-017: Without an effective write, no entry SHALL change; wb_sel=11 with WE=1 SHALL be treated as no write.
REQ-018: Reads SHALL be combinational: R1D1 = entry[RA1], R2D2 = entry[RA2], zero latency.
REQ-019: Write-through bypass: when an effective write targets WA equal to RA1 (resp. RA2), R1D1 (resp. R2D2) SHALL show wb_data in the same cycle, before the edge.
REQ-020: RA1=0 or RA2=0 SHALL return 0 regardless of WE/WA/bypass.
REQ-021: RA1=RA2 SHALL return identical values on both ports, including during bypass.
REQ-022: Only one write per cycle; consecutive writes to the same WA SHALL leave the last cycle's value.
REQ-023: All arithmetic-free; no width extension; write data is stored full 32 bits unmodified.

Reset
REQ-024: rst=1 SHALL immediately, without waiting for clk, clear all 32 entries to 0; R1D1, R2D2 SHALL read 0 while rst=1, bypass included.
REQ-025: While rst=1 no write SHALL take effect, even with an effective write presented on a clk edge.
REQ-026: Reset asserted mid-sequence SHALL discard any write in the same cycle; after rst falls, the first rising edge with an effective write SHALL store normally.
REQ-027: wb_data is combinational and SHALL follow inputs regardless of rst.

Verification
REQ-028: rst pulse between edges, then RA1=5, RA2=31 -> R1D1=0, R2D2=0 immediately after rst rises, without a clk edge.
REQ-029: WE=1, WA=7, wb_sel=00, alu_out=0xDEADBEEF, RA2=7 -> R2D2=0xDEADBEEF before edge (bypass) and after edge with WE=0 (stored).
REQ-030: WE=1, WA=0, wb_sel=01, mem_data=0x12345678, RA1=0 -> R1D1=0 before and after edge.
REQ-031: WE=1, WA=3, wb_sel=11, alu_out=0xAAAA5555, entry 3 = 0x1 beforehand -> entry 3 remains 0x1, wb_data=0.
REQ-032: WE=1, WA=1, wb_sel=10, pc_plus4=0x00000104, RA1=RA2=1 -> R1D1=R2D2=0x00000104; next cycle WA=1, wb_sel=00, alu_out=0x5 -> both ports read 0x5 after edge.
REQ-033: entry 9 = 0xCAFE0000, rst asserted at the same edge as WE=1, WA=9, alu_out=0x1 -> entry 9 reads 0 after rst falls; next edge with write stores 0x1.
